// File: rtl/word_serializer4.sv
`default_nettype none
// ============================================================================
// Module   : word_serializer4
// Purpose  : Accepts 4-bit words over valid/ready and emits them one bit per
//            cycle through a registered index counter. A one-word pending
//            buffer lets back-to-back words stream without bubbles; completed
//            words are counted on a wrapping counter.
// Revision : 1.0 - initial release
// ============================================================================
module word_serializer4 #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  // Bit order is fixed at elaboration: the index walks from start to end.
  localparam logic [1:0] C_IDX_START = MSB_FIRST ? 2'd3 : 2'd0;
  localparam logic [1:0] C_IDX_END   = MSB_FIRST ? 2'd0 : 2'd3;

  // Control FSM: IDLE means no active word, SHIFT means act_q is being emitted.
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       act_q, act_d;
  logic [3:0]       pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic act_v;
  logic ot;
  logic ia;
  logic lt;

  // Outputs and handshake events are pure functions of the registered state.
  always_comb begin
    act_v      = (state_q == S_SHIFT);
    out_valid  = act_v;
    out_bit    = act_q[idx_q] & act_v;
    out_last   = act_v & (idx_q == C_IDX_END);
    in_ready   = ~pend_v_q;
    busy       = act_v | pend_v_q;
    word_count = cnt_q;
    ot         = act_v & out_ready;
    ia         = in_valid & ~pend_v_q;
    lt         = ot & (idx_q == C_IDX_END);
  end

  // Next-state: advance the index, retire/reload words, park an early word.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;

    if (ot && !lt) begin
      idx_d = MSB_FIRST ? (idx_q - 2'd1) : (idx_q + 2'd1);
    end

    if (lt) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (pend_v_q) begin
        // The pending word takes over; ia cannot fire since in_ready is low.
        act_d    = pend_q;
        pend_v_d = 1'b0;
        idx_d    = C_IDX_START;
      end else if (ia) begin
        // A word arriving on the last bit goes straight to the active slot.
        act_d = in_data;
        idx_d = C_IDX_START;
      end else begin
        state_d = S_IDLE;
      end
    end

    if (ia && !act_v) begin
      act_d   = in_data;
      idx_d   = C_IDX_START;
      state_d = S_SHIFT;
    end else if (ia && act_v && !lt) begin
      pend_d   = in_data;
      pend_v_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      act_q    <= 4'd0;
      pend_q   <= 4'd0;
      pend_v_q <= 1'b0;
      idx_q    <= C_IDX_START;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_word_serializer4.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_serializer4
// Purpose  : Self-checking bench for word_serializer4: directed vector table,
//            hand-written multi-cycle sequences and randomized traffic against
//            a word-queue reference model. Two instances cover MSB-first with
//            an 8-bit counter and LSB-first with a 2-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_serializer4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_data = 4'd0;

  logic       a_ir, a_ob, a_ov, a_ol, a_bz;
  logic [7:0] a_wc;
  logic       b_ir, b_ob, b_ov, b_ol, b_bz;
  logic [1:0] b_wc;

  // Both instances see identical stimulus; sel picks which one is checked.
  bit         sel = 1'b0;
  logic       ir, ob, ov, ol, bz;
  logic [7:0] wc;

  always #5 clk = ~clk;

  word_serializer4 #(.MSB_FIRST(1'b1), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_ir), .out_bit(a_ob), .out_valid(a_ov), .out_ready(out_ready),
    .out_last(a_ol), .busy(a_bz), .word_count(a_wc)
  );

  word_serializer4 #(.MSB_FIRST(1'b0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_ir), .out_bit(b_ob), .out_valid(b_ov), .out_ready(out_ready),
    .out_last(b_ol), .busy(b_bz), .word_count(b_wc)
  );

  always_comb begin
    if (sel) begin
      ir = b_ir; ob = b_ob; ov = b_ov; ol = b_ol; bz = b_bz; wc = {6'd0, b_wc};
    end else begin
      ir = a_ir; ob = a_ob; ov = a_ov; ol = a_ol; bz = a_bz; wc = a_wc;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit eov, input bit eob, input bit eol,
                           input bit eir, input bit ebz, input int ecnt);
    chk({tag, " out_valid"}, 32'(ov), 32'(eov));
    chk({tag, " out_bit"},   32'(ob), 32'(eob));
    chk({tag, " out_last"},  32'(ol), 32'(eol));
    chk({tag, " in_ready"},  32'(ir), 32'(eir));
    chk({tag, " busy"},      32'(bz), 32'(ebz));
    chk({tag, " word_count"}, 32'(wc), ecnt);
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic step(input bit r, input bit v, input logic [3:0] d, input bit ordy);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Same as step, but logs the bit that transfers at this edge.
  bit got_bits[$];
  bit got_last;
  task automatic xfer(input bit r, input bit v, input logic [3:0] d, input bit ordy);
    got_last = 1'b0;
    if (!r && ov === 1'b1 && ordy) begin
      got_bits.push_back(ob);
      got_last = ol;
    end
    step(r, v, d, ordy);
  endtask

  // ---------------- reference model: a queue of held words ----------------
  logic [3:0] mq[$];
  int         mpos;
  int         mcnt;
  bit         m_msb;
  int         m_mask;

  task automatic model_edge(input bit r, input bit v, input logic [3:0] d, input bit ordy);
    bit accept;
    if (r) begin
      mq.delete(); mpos = 0; mcnt = 0;
    end else begin
      accept = v && (mq.size() < 2);
      if (mq.size() > 0 && ordy) begin
        if (mpos == 3) begin
          void'(mq.pop_front());
          mpos = 0;
          mcnt = (mcnt + 1) & m_mask;
        end else begin
          mpos++;
        end
      end
      if (accept) mq.push_back(d);
    end
  endtask

  task automatic model_check(input string tag);
    logic [3:0] w;
    int         b;
    bit         eov, eob, eol;
    eov = (mq.size() > 0);
    eob = 1'b0;
    eol = 1'b0;
    if (eov) begin
      w   = mq[0];
      b   = m_msb ? (3 - mpos) : mpos;
      eob = w[b];
      eol = (mpos == 3);
    end
    check_all(tag, eov, eob, eol, mq.size() < 2, mq.size() > 0, mcnt);
  endtask

  // ---------------- directed vector table (instance A) ----------------
  typedef struct {
    bit rst; bit iv; logic [3:0] d; bit ordy;
    bit ov; bit ob; bit ol; bit ir; bit bz; int cnt;
  } vec_t;

  vec_t tbl[20];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         accepted;
    int         counts[$];
    logic [3:0] pat;
    bit         v;
    logic [3:0] d;
    bit         r_ordy;

    // Reset with a handshake offered, then 1011 MSB-first, then A,5,C streamed.
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    tbl[4]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    tbl[5]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[8]  = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[9]  = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    tbl[10] = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[11] = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    tbl[12] = '{1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2};
    tbl[15] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3};
    tbl[16] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3};
    tbl[17] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    tbl[18] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3};
    tbl[19] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4};

    sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      check_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].ob, tbl[i].ol,
                tbl[i].ir, tbl[i].bz, tbl[i].cnt);
    end

    // ---- backpressure: 0110 with out_ready low in cycles 2..5 ----
    step(1'b1, 1'b0, 4'h0, 1'b0);
    got_bits.delete();
    xfer(1'b0, 1'b1, 4'h6, 1'b1);
    xfer(1'b0, 1'b0, 4'h0, 1'b1);
    for (int c = 2; c <= 5; c++) begin
      xfer(1'b0, 1'b0, 4'h0, 1'b0);
      chk($sformatf("bp stall%0d out_bit", c), 32'(ob), 32'd1);
      chk($sformatf("bp stall%0d out_last", c), 32'(ol), 32'd0);
    end
    for (int c = 0; c < 3; c++) xfer(1'b0, 1'b0, 4'h0, 1'b1);
    chk("bp bit count", got_bits.size(), 4);
    pat = 4'b0110;
    for (int k = 0; k < 4 && k < got_bits.size(); k++)
      chk($sformatf("bp bit%0d", k), 32'(got_bits[k]), 32'(pat[3-k]));
    chk("bp out_valid after", 32'(ov), 32'd0);
    chk("bp word_count", 32'(wc), 32'd1);

    // ---- LSB-first order and 2-bit counter wrap (instance B) ----
    sel = 1'b1;
    step(1'b1, 1'b0, 4'h0, 1'b1);
    got_bits.delete();
    accepted = 0;
    for (int c = 0; c < 40 && counts.size() < 5; c++) begin
      v = (accepted < 5);
      if (v && ir === 1'b1) accepted++;
      xfer(1'b0, v, 4'h1, 1'b1);
      if (got_last) counts.push_back(int'(wc));
    end
    chk("lsb words retired", counts.size(), 5);
    for (int k = 0; k < counts.size(); k++)
      chk($sformatf("lsb count after word%0d", k), counts[k], (k + 1) % 4);
    chk("lsb bit count", got_bits.size(), 20);
    for (int k = 0; k < got_bits.size(); k++)
      chk($sformatf("lsb bit%0d", k), 32'(got_bits[k]), 32'((k % 4) == 0));

    // ---- reset mid-word with a pending word (instance A) ----
    sel = 1'b0;
    step(1'b1, 1'b0, 4'h0, 1'b1);
    got_bits.delete();
    xfer(1'b0, 1'b1, 4'h9, 1'b1);
    xfer(1'b0, 1'b1, 4'h3, 1'b1);
    chk("rmw pending in_ready", 32'(ir), 32'd0);
    xfer(1'b0, 1'b0, 4'h0, 1'b1);
    chk("rmw two bits out", got_bits.size(), 2);
    xfer(1'b1, 1'b1, 4'hF, 1'b1);
    check_all("rmw after reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int c = 0; c < 10; c++) xfer(1'b0, 1'b0, 4'h0, 1'b1);
    chk("rmw nothing emitted", got_bits.size(), 2);
    chk("rmw idle out_valid", 32'(ov), 32'd0);

    // ---- randomized traffic against the reference model, both instances ----
    for (int s = 0; s < 2; s++) begin
      sel    = (s == 1);
      m_msb  = (s == 0);
      m_mask = (s == 0) ? 255 : 3;
      step(1'b1, 1'b0, 4'h0, 1'b0);
      model_edge(1'b1, 1'b0, 4'h0, 1'b0);
      for (int c = 0; c < 500; c++) begin
        v      = ($urandom_range(0, 99) < 70);
        d      = 4'($urandom);
        r_ordy = ($urandom_range(0, 99) < 70);
        step(1'b0, v, d, r_ordy);
        model_edge(1'b0, v, d, r_ordy);
        model_check($sformatf("rnd%0d c%0d", s, c));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
